// File: rtl/ni_packetizer_pkg.sv
// Shared flit definitions for the router and the network interface:
// type codes, field offsets and the parity rule.
package ni_packetizer_pkg;

    localparam int FLIT_W = 32;
    localparam int LEN_W  = 12;
    localparam int PL_W   = 28;

    localparam logic [LEN_W-1:0] MAX_LEN = 12'd4094;

    localparam logic [2:0] FLIT_HEAD = 3'b001;
    localparam logic [2:0] FLIT_BODY = 3'b010;
    localparam logic [2:0] FLIT_TAIL = 3'b100;

    localparam int OFS_TYPE = 29;
    localparam int OFS_LEN  = 17;
    localparam int OFS_DST  = 13;
    localparam int OFS_SRC  = 9;
    localparam int OFS_ID   = 1;

    typedef enum logic [1:0] {IDLE, HEAD, PAYLD, GAP} state_t;

    // Bit 0 of a flit makes the whole word even parity.
    function automatic logic even_parity(input logic [FLIT_W-1:1] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ni_packetizer_if.sv
// Core-side command/payload handshake plus the router local-port link.
interface ni_packetizer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int AXIS       = 4
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [AXIS-1:0]       cmd_dst;
    logic [11:0]           cmd_len;
    logic                  pl_valid;
    logic                  pl_ready;
    logic [27:0]           pl_data;
    logic [DATA_WIDTH-1:0] tx;
    logic                  drts;
    logic                  cts;
    logic                  busy;
    logic                  pkt_done;
    logic                  cmd_err;

    modport master (
        output cmd_valid, cmd_dst, cmd_len, pl_valid, pl_data, cts,
        input  cmd_ready, pl_ready, tx, drts, busy, pkt_done, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_dst, cmd_len, pl_valid, pl_data, cts,
        output cmd_ready, pl_ready, tx, drts, busy, pkt_done, cmd_err
    );
endinterface

// File: rtl/ni_flit_fmt.sv
// Combinational flit builder: header fields or payload under a type code,
// with even parity in bit 0.
module ni_flit_fmt
    import ni_packetizer_pkg::*;
#(
    parameter int DATA_WIDTH = FLIT_W,
    parameter int AXIS       = 4,
    parameter int PKT_ID_W   = 8
) (
    input  logic [2:0]            ftype,
    input  logic [LEN_W-1:0]      flit_cnt,
    input  logic [AXIS-1:0]       dst,
    input  logic [AXIS-1:0]       src,
    input  logic [PKT_ID_W-1:0]   pkt_id,
    input  logic [PL_W-1:0]       payload,
    output logic [DATA_WIDTH-1:0] flit
);
    logic [DATA_WIDTH-1:1] fields;

    always_comb begin
        fields = '0;
        if (ftype == FLIT_HEAD) begin
            fields[OFS_LEN +: LEN_W]   = flit_cnt;
            fields[OFS_DST +: AXIS]     = dst;
            fields[OFS_SRC +: AXIS]     = src;
            fields[OFS_ID  +: PKT_ID_W] = pkt_id;
        end else begin
            fields[OFS_ID +: PL_W] = payload;
        end
        fields[OFS_TYPE +: 3] = ftype;
    end

    assign flit = {fields, even_parity(fields)};
endmodule

// File: rtl/ni_packetizer.sv
// Injection stage in front of the router local port: frames a command and its
// payload stream into header/body/tail flits, one flit at most every 2 cycles.
module ni_packetizer
    import ni_packetizer_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          AXIS       = 4,
    parameter logic [3:0]  SRC_ADDR   = 4'b0010,
    parameter int          PKT_ID_W   = 8
) (
    input logic       clk,
    input logic       rst,
    ni_packetizer_if.slave bus
);
    state_t                state;
    state_t                after_gap;
    logic [AXIS-1:0]       dst_q;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      remaining;
    logic [LEN_W-1:0]      hdr_len;
    logic [PKT_ID_W-1:0]   pkt_id;
    logic [DATA_WIDTH-1:0] tx_q;
    logic [DATA_WIDTH-1:0] flit;
    logic [2:0]            ftype;
    logic                  drts_q, pkt_done_q, cmd_err_q, cmd_ready_q, busy_q;
    logic                  len_ok, pl_fire;

    assign bus.pl_ready  = (state == PAYLD) && bus.cts;
    assign bus.tx        = tx_q;
    assign bus.drts      = drts_q;
    assign bus.pkt_done  = pkt_done_q;
    assign bus.cmd_err   = cmd_err_q;
    assign bus.cmd_ready = cmd_ready_q;
    assign bus.busy      = busy_q;

    assign pl_fire = bus.pl_valid && bus.pl_ready;
    assign len_ok  = (bus.cmd_len != '0) && (bus.cmd_len <= MAX_LEN);
    assign hdr_len = len_q + 12'd1;
    assign ftype   = (state == HEAD)          ? FLIT_HEAD :
                     (remaining == 12'd1)     ? FLIT_TAIL : FLIT_BODY;

    ni_flit_fmt #(.DATA_WIDTH(DATA_WIDTH), .AXIS(AXIS), .PKT_ID_W(PKT_ID_W)) u_fmt (
        .ftype    (ftype),
        .flit_cnt (hdr_len),
        .dst      (dst_q),
        .src      (SRC_ADDR),
        .pkt_id   (pkt_id),
        .payload  (bus.pl_data),
        .flit     (flit)
    );

    // Every flit is followed by a GAP cycle so the router's cts is re-sampled
    // after each write into its FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            after_gap   <= IDLE;
            dst_q       <= '0;
            len_q       <= '0;
            remaining   <= '0;
            pkt_id      <= '0;
            tx_q        <= '0;
            drts_q      <= 1'b0;
            pkt_done_q  <= 1'b0;
            cmd_err_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            drts_q     <= 1'b0;
            pkt_done_q <= 1'b0;
            cmd_err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        if (len_ok) begin
                            dst_q       <= bus.cmd_dst;
                            len_q       <= bus.cmd_len;
                            remaining   <= bus.cmd_len;
                            state       <= HEAD;
                            cmd_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                        end else begin
                            cmd_err_q <= 1'b1;
                        end
                    end
                end
                HEAD: begin
                    if (bus.cts) begin
                        tx_q      <= flit;
                        drts_q    <= 1'b1;
                        state     <= GAP;
                        after_gap <= PAYLD;
                    end
                end
                PAYLD: begin
                    if (pl_fire) begin
                        tx_q      <= flit;
                        drts_q    <= 1'b1;
                        remaining <= remaining - 12'd1;
                        state     <= GAP;
                        if (remaining == 12'd1) begin
                            after_gap  <= IDLE;
                            pkt_id     <= pkt_id + 1'b1;
                            pkt_done_q <= 1'b1;
                        end else begin
                            after_gap <= PAYLD;
                        end
                    end
                end
                GAP: begin
                    state <= after_gap;
                    if (after_gap == IDLE) begin
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ni_packetizer.sv
// Bench for ni_packetizer: flit scoreboard from a packet-level model, table of
// commands, directed corner sequences and randomized cts/payload traffic.
module tb_ni_packetizer;
    import ni_packetizer_pkg::*;

    localparam logic [3:0] SRC = 4'b0010;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ni_packetizer_if bus ();
    ni_packetizer #(.SRC_ADDR(SRC)) dut (.clk(clk), .rst(rst), .bus(bus));

    int          tests = 0, fails = 0;
    logic [31:0] exp_q[$];
    logic [31:0] seen_q[$];
    int          seen_cyc[$];
    logic [27:0] pl_q[$];
    logic [7:0]  model_id = 8'd0;
    int          flit_cnt = 0, err_seen = 0, cyc = 0;
    bit          cts_rand = 0, cts_force = 1, pl_gaps = 0;
    logic        cts_at_edge = 1'b0;

    typedef struct {
        logic [3:0]  dst;
        logic [11:0] len;
        int          exp_err;
        int          exp_flits;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired or event missing", name);
    endtask

    // Flit built from field arithmetic; parity by counting ones.
    function automatic logic [31:0] make_flit(input logic [2:0] t, input logic [27:0] f);
        logic [31:0] w;
        w    = {t, f, 1'b0};
        w[0] = ($countones(w) % 2) == 1;
        return w;
    endfunction

    function automatic logic [27:0] hdr_fields(input logic [3:0] dst, input logic [11:0] len,
                                               input logic [7:0] id);
        return 28'((int'(len) + 1) * 65536 + int'(dst) * 4096 + int'(SRC) * 256 + int'(id));
    endfunction

    always @(posedge clk) cts_at_edge <= bus.cts;

    initial begin
        bus.cts = 1'b1;
        forever begin
            @(negedge clk);
            bus.cts = cts_rand ? ($urandom_range(0, 2) != 0) : cts_force;
        end
    end

    // Payload source: offers the head of pl_q, consumes it on handshake.
    initial begin
        bus.pl_valid = 1'b0;
        bus.pl_data  = '0;
        forever begin
            @(negedge clk);
            if (pl_q.size() > 0 && (!pl_gaps || $urandom_range(0, 3) != 0)) begin
                bus.pl_valid = 1'b1;
                bus.pl_data  = pl_q[0];
            end else begin
                bus.pl_valid = 1'b0;
            end
            #1;
            if (bus.pl_valid && bus.pl_ready) void'(pl_q.pop_front());
        end
    end

    initial begin
        logic        prev_drts;
        logic [31:0] tx_prev;
        logic [31:0] e;
        prev_drts = 1'b0;
        tx_prev   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cyc++;
                err_seen += int'(bus.cmd_err);
                if (bus.drts) begin
                    flit_cnt++;
                    seen_q.push_back(bus.tx);
                    seen_cyc.push_back(cyc);
                    check("drts_consecutive", {31'd0, prev_drts}, 32'd0);
                    check("drts_without_cts", {31'd0, cts_at_edge}, 32'd1);
                    if (exp_q.size() == 0) fail_now("unexpected_flit");
                    else begin
                        e = exp_q.pop_front();
                        check("flit", bus.tx, e);
                        check("pkt_done_on_tail", {31'd0, bus.pkt_done}, {31'd0, e[31]});
                    end
                end else begin
                    check("tx_hold", bus.tx, tx_prev);
                    check("pkt_done_stray", {31'd0, bus.pkt_done}, 32'd0);
                end
            end
            prev_drts = bus.drts;
            tx_prev   = bus.tx;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_tx"},        bus.tx, 32'd0);
        check({tag, "_drts"},      {31'd0, bus.drts}, 32'd0);
        check({tag, "_busy"},      {31'd0, bus.busy}, 32'd0);
        check({tag, "_pkt_done"},  {31'd0, bus.pkt_done}, 32'd0);
        check({tag, "_cmd_err"},   {31'd0, bus.cmd_err}, 32'd0);
        check({tag, "_cmd_ready"}, {31'd0, bus.cmd_ready}, 32'd1);
        check({tag, "_pl_ready"},  {31'd0, bus.pl_ready}, 32'd0);
    endtask

    task automatic issue_cmd(input logic [3:0] dst, input logic [11:0] len, input logic [27:0] first);
        bit legal;
        int budget;
        legal = (len >= 12'd1) && (len <= 12'd4094);
        if (legal) begin
            exp_q.push_back(make_flit(3'b001, hdr_fields(dst, len, model_id)));
            for (int i = 0; i < int'(len); i++) begin
                exp_q.push_back(make_flit((i == int'(len) - 1) ? 3'b100 : 3'b010, first + 28'(i)));
                pl_q.push_back(first + 28'(i));
            end
            model_id++;
        end
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_dst   = dst;
        bus.cmd_len   = len;
        #1;
        budget = 0;
        while (!bus.cmd_ready && budget < 200) begin
            @(negedge clk);
            #1;
            budget++;
        end
        if (budget >= 200) fail_now("cmd_accept_timeout");
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("busy_after_cmd", {31'd0, bus.busy}, {31'd0, legal});
    endtask

    task automatic wait_idle(input int budget);
        int b;
        b = 0;
        while ((bus.busy || pl_q.size() != 0 || exp_q.size() != 0) && b < budget) begin
            @(negedge clk);
            b++;
        end
        if (b >= budget) begin
            fail_now("idle_timeout");
            exp_q.delete();
            pl_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic send_pkt(input logic [3:0] dst, input logic [11:0] len, input logic [27:0] first);
        issue_cmd(dst, len, first);
        wait_idle(4 * int'(len) + 100);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        pl_q.delete();
        model_id = 8'd0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        vec_t       vecs[6];
        logic [2:0] types[4];
        int         f0, e0, b;
        logic [11:0] rl;
        bit          legal;

        bus.cmd_valid = 1'b0;
        bus.cmd_dst   = '0;
        bus.cmd_len   = '0;

        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b1;
        @(negedge clk);

        // Single-word packet with hand-computed flit words.
        seen_q.delete();
        send_pkt(4'd1, 12'd1, 28'h0ABCDEF);
        check("d1_nflits", seen_q.size(), 32'd2);
        if (seen_q.size() == 2) begin
            check("d1_header", seen_q[0], 32'h2004_2400);
            check("d1_tail",   seen_q[1], 32'h8157_9BDE);
        end

        // Three words: type sequence, length field, 2-cycle spacing.
        seen_q.delete();
        seen_cyc.delete();
        types = '{3'b001, 3'b010, 3'b010, 3'b100};
        send_pkt(4'd3, 12'd3, 28'd1);
        check("d3_nflits", seen_q.size(), 32'd4);
        if (seen_q.size() == 4) begin
            check("d3_len_field", {20'd0, seen_q[0][28:17]}, 32'd4);
            for (int i = 0; i < 4; i++) begin
                check($sformatf("d3_type%0d", i), {29'd0, seen_q[i][31:29]}, {29'd0, types[i]});
                if (i > 0) check($sformatf("d3_spacing%0d", i), seen_cyc[i] - seen_cyc[i-1], 32'd2);
            end
        end

        // cts held low in HEAD and again mid-payload.
        cts_force = 1'b0;
        @(negedge clk);
        seen_q.delete();
        f0 = flit_cnt;
        issue_cmd(4'd6, 12'd3, 28'h1234560);
        repeat (10) begin
            @(negedge clk);
            #2;
            check("stall_head_pl_ready", {31'd0, bus.pl_ready}, 32'd0);
            check("stall_head_busy", {31'd0, bus.busy}, 32'd1);
        end
        check("stall_head_no_drts", flit_cnt - f0, 32'd0);
        cts_force = 1'b1;
        b = 0;
        while (seen_q.size() < 2 && b < 50) begin
            @(negedge clk);
            b++;
        end
        if (b >= 50) fail_now("stall_resume_timeout");
        cts_force = 1'b0;
        @(negedge clk);
        f0 = flit_cnt;
        repeat (10) begin
            @(negedge clk);
            #2;
            check("stall_payld_pl_ready", {31'd0, bus.pl_ready}, 32'd0);
        end
        check("stall_payld_no_drts", flit_cnt - f0, 32'd0);
        cts_force = 1'b1;
        wait_idle(100);
        check("stall_total_flits", seen_q.size(), 32'd4);

        // Command table, including the length boundaries.
        vecs[0] = '{4'd1,  12'd1,    0, 2};
        vecs[1] = '{4'd5,  12'd3,    0, 4};
        vecs[2] = '{4'd0,  12'd0,    1, 0};
        vecs[3] = '{4'd15, 12'd4095, 1, 0};
        vecs[4] = '{4'd9,  12'd4094, 0, 4095};
        vecs[5] = '{4'd12, 12'd2,    0, 3};
        for (int i = 0; i < 6; i++) begin
            f0 = flit_cnt;
            e0 = err_seen;
            send_pkt(vecs[i].dst, vecs[i].len, 28'($urandom));
            check($sformatf("vec%0d_flits", i), flit_cnt - f0, vecs[i].exp_flits);
            check($sformatf("vec%0d_err", i), err_seen - e0, vecs[i].exp_err);
            check($sformatf("vec%0d_idle", i), {30'd0, bus.busy, bus.cmd_ready}, 32'd1);
        end

        // Random traffic with random cts and payload gaps.
        cts_rand = 1;
        pl_gaps  = 1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) rl = ($urandom_range(0, 1) == 0) ? 12'd0 : 12'd4095;
            else rl = 12'($urandom_range(1, 6));
            legal = (rl != 12'd0) && (rl != 12'd4095);
            f0 = flit_cnt;
            e0 = err_seen;
            send_pkt(4'($urandom), rl, 28'($urandom));
            check($sformatf("rnd%0d_flits", i), flit_cnt - f0, legal ? int'(rl) + 1 : 0);
            check($sformatf("rnd%0d_err", i), err_seen - e0, legal ? 0 : 1);
        end
        cts_rand = 0;
        pl_gaps  = 0;

        // 257 single-word packets: ids wrap 255 -> 0 (scoreboard checks ids).
        pulse_reset();
        seen_q.delete();
        f0 = flit_cnt;
        for (int i = 0; i < 257; i++) send_pkt(4'($urandom), 12'd1, 28'($urandom));
        check("wrap_flits", flit_cnt - f0, 32'd514);
        if (seen_q.size() == 514) begin
            check("wrap_id255", {24'd0, seen_q[510][8:1]}, 32'd255);
            check("wrap_id0",   {24'd0, seen_q[512][8:1]}, 32'd0);
        end

        // Reset in PAYLD after 2 of 5 words.
        issue_cmd(4'd7, 12'd5, 28'hA000000);
        b = 0;
        while (pl_q.size() > 3 && b < 100) begin
            @(negedge clk);
            #2;
            b++;
        end
        if (b >= 100) fail_now("midpkt_progress_timeout");
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_reset_vals("midrst");
        exp_q.delete();
        pl_q.delete();
        model_id = 8'd0;
        @(negedge clk);
        rst = 1'b1;
        seen_q.delete();
        send_pkt(4'd4, 12'd2, 28'h0000055);
        check("post_rst_flits", seen_q.size(), 32'd3);
        if (seen_q.size() == 3) check("post_rst_id", {24'd0, seen_q[0][8:1]}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
